// File: rtl/codec_pkg.sv
// Shared constants and helpers for the codec I2S transmit and receive paths.
// Slot layout: 32-bit slots, 24-bit samples MSB-first starting one BCLK after the LRCK edge.
package codec_pkg;
    localparam int SMPL_W     = 24;
    localparam int SLOT_BITS  = 32;
    localparam int FRAME_BITS = 64;
    localparam int CH_L       = 0;
    localparam int CH_R       = 1;
    localparam int DATA_START = 1;
    localparam int DATA_END   = 24;

    typedef logic [SMPL_W-1:0]              sample_t;
    typedef logic [$clog2(FRAME_BITS)-1:0]  bit_idx_t;
    typedef logic [$clog2(SLOT_BITS)-1:0]   slot_pos_t;

    // Serial bit for slot position p: sample MSB at p=1, zero padding elsewhere.
    function automatic logic slot_bit(input sample_t w, input slot_pos_t p);
        logic [4:0] idx;
        idx = 5'(SMPL_W) - p;
        return (p >= slot_pos_t'(DATA_START) && p <= slot_pos_t'(DATA_END)) ? w[idx] : 1'b0;
    endfunction
endpackage

// File: rtl/codec_bclk_gen.sv
// Bit-clock generator: divides clk by 2*CLK_DIV and flags the cycles in which
// bclk is about to toggle, so callers can act in lockstep with the registered edge.
module codec_bclk_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    output logic bclk_o,
    output logic fall_o,
    output logic rise_o
);
    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

    logic [DW-1:0] div_cnt_q, div_cnt_d;
    logic          bclk_q, bclk_d;
    logic          wrap;

    assign wrap = (div_cnt_q == DIV_LAST);

    always_comb begin
        div_cnt_d = wrap ? '0 : div_cnt_q + DW'(1);
        bclk_d    = wrap ? ~bclk_q : bclk_q;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            div_cnt_q <= '0;
            bclk_q    <= 1'b0;
        end else begin
            div_cnt_q <= div_cnt_d;
            bclk_q    <= bclk_d;
        end
    end

    assign bclk_o = bclk_q;
    assign fall_o = wrap & bclk_q;
    assign rise_o = wrap & ~bclk_q;
endmodule

// File: rtl/codec_i2s_tx.sv
// I2S transmitter: double-buffers one 24-bit sample per channel and shifts the
// active pair out MSB-first, one BCLK after each LRCK edge, 64 BCLK per frame.
module codec_i2s_tx
    import codec_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [1:0]        din_valid_i,
    input  logic [SMPL_W-1:0] din_i,
    output logic              bclk_o,
    output logic              lrck_o,
    output logic              sdata_o,
    output logic              frame_start_o,
    output logic [1:0]        underrun_o
);
    logic      fall;
    logic      unused_rise;
    bit_idx_t  bit_cnt_q, bit_cnt_d, n;
    slot_pos_t p;
    sample_t   w;
    logic      lrck_q, lrck_d, sdata_q, sdata_d, frame_start_q, frame_start_d;
    logic [1:0] underrun_q, underrun_d, fresh_q, fresh_d, seen_q, seen_d;
    sample_t   pending_q [2];
    sample_t   pending_d [2];
    sample_t   active_q  [2];
    sample_t   active_d  [2];

    codec_bclk_gen #(.CLK_DIV(CLK_DIV)) u_bclk (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .bclk_o (bclk_o),
        .fall_o (fall),
        .rise_o (unused_rise)
    );

    // n is the bit that goes out after this fall; n==0 is the frame boundary.
    assign n = bit_cnt_q + bit_idx_t'(1);
    assign p = n[4:0];
    assign w = n[5] ? active_q[CH_R] : active_q[CH_L];

    always_comb begin
        bit_cnt_d     = bit_cnt_q;
        lrck_d        = lrck_q;
        sdata_d       = sdata_q;
        frame_start_d = 1'b0;
        underrun_d    = '0;
        pending_d     = pending_q;
        active_d      = active_q;
        fresh_d       = fresh_q;
        seen_d        = seen_q;
        if (fall) begin
            bit_cnt_d = n;
            lrck_d    = n[5];
            sdata_d   = slot_bit(w, p);
            if (n == '0) begin
                active_d      = pending_q;
                frame_start_d = 1'b1;
                underrun_d    = seen_q & ~fresh_q;
                fresh_d       = '0;
            end
        end
        // A write in the latch cycle overrides the clear and counts for the next frame.
        for (int ch = 0; ch < 2; ch++) begin
            if (din_valid_i[ch]) begin
                pending_d[ch] = din_i;
                fresh_d[ch]   = 1'b1;
                seen_d[ch]    = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            bit_cnt_q     <= '1;
            lrck_q        <= 1'b0;
            sdata_q       <= 1'b0;
            frame_start_q <= 1'b0;
            underrun_q    <= '0;
            pending_q     <= '{default: '0};
            active_q      <= '{default: '0};
            fresh_q       <= '0;
            seen_q        <= '0;
        end else begin
            bit_cnt_q     <= bit_cnt_d;
            lrck_q        <= lrck_d;
            sdata_q       <= sdata_d;
            frame_start_q <= frame_start_d;
            underrun_q    <= underrun_d;
            pending_q     <= pending_d;
            active_q      <= active_d;
            fresh_q       <= fresh_d;
            seen_q        <= seen_d;
        end
    end

    assign lrck_o        = lrck_q;
    assign sdata_o       = sdata_q;
    assign frame_start_o = frame_start_q;
    assign underrun_o    = underrun_q;
endmodule

// File: tb/tb_codec_i2s_tx.sv
// Directed bench for codec_i2s_tx at CLK_DIV=4: frame timing, slot contents,
// underrun reporting, latch-cycle write priority and mid-frame reset.
module tb_codec_i2s_tx;
    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  din_valid;
    logic [23:0] din;
    logic        bclk, lrck, sdata, frame_start;
    logic [1:0]  underrun;

    int n_chk  = 0;
    int n_pass = 0;

    localparam logic [63:0] LR_PAT   = 64'hFFFF_FFFF_0000_0000;
    localparam logic [63:0] PAD_MASK = 64'hFE00_0001_FE00_0001;

    codec_i2s_tx #(.CLK_DIV(4)) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .din_valid_i   (din_valid),
        .din_i         (din),
        .bclk_o        (bclk),
        .lrck_o        (lrck),
        .sdata_o       (sdata),
        .frame_start_o (frame_start),
        .underrun_o    (underrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [23:0] slot_data(input logic [63:0] sd, input int base);
        logic [23:0] d;
        for (int p = 1; p <= 24; p++) d[24-p] = sd[base+p];
        return d;
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        din_valid = '0;
        din = '0;
        repeat (3) tick();
        check("rst_outputs", {59'd0, bclk, lrck, sdata, frame_start, underrun != 2'b00}, 64'd0);
        rst = 1'b0;
    endtask

    task automatic wait_fs(input string tag, output int lat);
        lat = 0;
        for (int i = 0; i < 1100; i++) begin
            tick();
            lat++;
            if (frame_start) break;
        end
        check({tag, "_fs_seen"}, {63'd0, frame_start}, 64'd1);
    endtask

    // Captures one frame starting at a frame_start sample point and checks its contents.
    task automatic run_frame(input string tag, input logic [23:0] exp_l, input logic [23:0] exp_r,
                             input int wc0, input logic [1:0] wv0, input logic [23:0] wd0,
                             input int wc1, input logic [1:0] wv1, input logic [23:0] wd1);
        logic [63:0] sd, lr;
        logic [1:0]  ur_mid;
        int          fs_mid;
        logic        bk_lo, bk_hi;
        sd = '0; lr = '0; ur_mid = '0; fs_mid = 0; bk_lo = 1'b0; bk_hi = 1'b1;
        for (int c = 0; c < 512; c++) begin
            if (c % 8 == 0) begin
                sd[c/8] = sdata;
                lr[c/8] = lrck;
            end
            if (c != 0) begin
                ur_mid |= underrun;
                fs_mid += int'(frame_start);
            end
            if (c % 8 < 4) bk_lo |= bclk;
            else           bk_hi &= bclk;
            if (c == wc0) begin
                din_valid = wv0;
                din = wd0;
            end else if (c == wc1) begin
                din_valid = wv1;
                din = wd1;
            end
            tick();
            din_valid = '0;
        end
        check({tag, "_left"},   {40'd0, slot_data(sd, 0)},  {40'd0, exp_l});
        check({tag, "_right"},  {40'd0, slot_data(sd, 32)}, {40'd0, exp_r});
        check({tag, "_pad"},    sd & PAD_MASK, 64'd0);
        check({tag, "_lrck"},   lr, LR_PAT);
        check({tag, "_bclk"},   {62'd0, bk_hi, bk_lo}, 64'd2);
        check({tag, "_ur_mid"}, {62'd0, ur_mid}, 64'd0);
        check({tag, "_fs_mid"}, 64'(fs_mid), 64'd0);
        check({tag, "_fs_next"}, {63'd0, frame_start}, 64'd1);
    endtask

    initial begin
        int lat;
        rst = 1'b1;
        din_valid = '0;
        din = '0;

        // Idle after reset: timing only, silent data.
        do_reset();
        wait_fs("s1", lat);
        check("s1_latency", 64'(lat), 64'd8);
        check("s1_f0_state", {60'd0, bclk, lrck, underrun}, 64'd0);
        run_frame("s1f0", 24'h0, 24'h0, -1, 2'b00, 24'h0, -1, 2'b00, 24'h0);
        check("s1_f1_ur", {62'd0, underrun}, 64'd0);

        // Samples written before the first latch, then repeat on underrun.
        do_reset();
        din_valid = 2'b01; din = 24'hA5A5A5;
        tick();
        din_valid = 2'b10; din = 24'h5A5A5A;
        tick();
        din_valid = 2'b00;
        wait_fs("s2", lat);
        check("s2_latency", 64'(lat), 64'd6);
        check("s2_f0_ur", {62'd0, underrun}, 64'd0);
        run_frame("s2f0", 24'hA5A5A5, 24'h5A5A5A, 10, 2'b01, 24'h800000, 20, 2'b10, 24'h7FFFFF);
        check("s2_f1_ur", {62'd0, underrun}, 64'd0);
        run_frame("s2f1", 24'h800000, 24'h7FFFFF, -1, 2'b00, 24'h0, -1, 2'b00, 24'h0);
        check("s2_f2_ur", {62'd0, underrun}, 64'd3);
        run_frame("s2f2", 24'h800000, 24'h7FFFFF, -1, 2'b00, 24'h0, -1, 2'b00, 24'h0);
        check("s2_f3_ur", {62'd0, underrun}, 64'd3);

        // Left fed every frame, right only once; latch-cycle write priority.
        do_reset();
        wait_fs("s3", lat);
        check("s3_f0_ur", {62'd0, underrun}, 64'd0);
        run_frame("s3f0", 24'h0, 24'h0, 10, 2'b01, 24'h111111, 20, 2'b10, 24'h222222);
        check("s3_f1_ur", {62'd0, underrun}, 64'd0);
        run_frame("s3f1", 24'h111111, 24'h222222, 10, 2'b01, 24'h333333, -1, 2'b00, 24'h0);
        check("s3_f2_ur", {62'd0, underrun}, 64'd2);
        run_frame("s3f2", 24'h333333, 24'h222222, 10, 2'b01, 24'h555555, 511, 2'b01, 24'h123456);
        check("s3_f3_ur", {62'd0, underrun}, 64'd2);
        run_frame("s3f3", 24'h555555, 24'h222222, -1, 2'b00, 24'h0, -1, 2'b00, 24'h0);
        check("s3_f4_ur", {62'd0, underrun}, 64'd2);
        run_frame("s3f4", 24'h123456, 24'h222222, 10, 2'b01, 24'hABCDEF, 20, 2'b10, 24'hFEDCBA);
        check("s3_f5_ur", {62'd0, underrun}, 64'd0);

        // Reset in the right slot at bit 42 (p=10 of 0xFEDCBA is 1).
        repeat (336) tick();
        check("s4_pre_rst", {62'd0, lrck, sdata}, 64'd3);
        rst = 1'b1;
        tick();
        check("s4_rst_out", {61'd0, bclk, lrck, sdata}, 64'd0);
        rst = 1'b0;
        wait_fs("s4", lat);
        check("s4_latency", 64'(lat), 64'd8);
        check("s4_f0_ur", {62'd0, underrun}, 64'd0);
        run_frame("s4f0", 24'h0, 24'h0, -1, 2'b00, 24'h0, -1, 2'b00, 24'h0);
        check("s4_f1_ur", {62'd0, underrun}, 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
